// File: rtl/sys_defs.sv
// sys_defs: shared row geometry, row type and feeder FSM states.
package sys_defs;
  localparam int ARR_WIDTH = 4;
  localparam int FXP_N = 16;
  typedef logic signed [ARR_WIDTH-1:0][FXP_N-1:0] row_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} feeder_state_e;
endpackage

// File: rtl/vector_row_feeder_if.sv
// vector_row_feeder_if: command, SA stream, SRAM, vector_unit and write-back signals.
// Perf counter outputs exist only when VEC_FEEDER_PERF_EN is defined.
interface vector_row_feeder_if import sys_defs::*; #(parameter int ADDR_W = 8);
  logic              cmd_valid, cmd_ready, cmd_mode;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W:0]   cmd_len;
  logic              sa_valid, sa_ready;
  row_t              sa_row;
  logic              int_rd_en, rec_rd_en, rec_wr_en;
  logic [ADDR_W-1:0] int_rd_addr, rec_rd_addr, rec_wr_addr;
  row_t              int_rd_data, rec_rd_data, rec_wr_data;
  logic              vu_enable, vu_mode;
  row_t              vu_sa_row, vu_int_row, vu_rec_row, vu_vec_out;
  logic              busy, done;
`ifdef VEC_FEEDER_PERF_EN
  logic [31:0]       perf_busy_cycles, perf_bubble_cycles;
`endif
  modport master (
    input  cmd_valid, cmd_base, cmd_len, cmd_mode, sa_valid, sa_row,
           int_rd_data, rec_rd_data, vu_vec_out,
    output cmd_ready, sa_ready, int_rd_en, int_rd_addr, rec_rd_en, rec_rd_addr,
           vu_enable, vu_mode, vu_sa_row, vu_int_row, vu_rec_row,
           rec_wr_en, rec_wr_addr, rec_wr_data, busy, done
`ifdef VEC_FEEDER_PERF_EN
    , output perf_busy_cycles, perf_bubble_cycles
`endif
  );
  modport slave (
    output cmd_valid, cmd_base, cmd_len, cmd_mode, sa_valid, sa_row,
           int_rd_data, rec_rd_data, vu_vec_out,
    input  cmd_ready, sa_ready, int_rd_en, int_rd_addr, rec_rd_en, rec_rd_addr,
           vu_enable, vu_mode, vu_sa_row, vu_int_row, vu_rec_row,
           rec_wr_en, rec_wr_addr, rec_wr_data, busy, done
`ifdef VEC_FEEDER_PERF_EN
    , input perf_busy_cycles, perf_bubble_cycles
`endif
  );
endinterface

// File: rtl/vec_tag_pipe.sv
// vec_tag_pipe: {valid,addr} delay line; exposes every valid stage and the last address.
module vec_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [AW-1:0]    i_addr,
  output logic [DEPTH-1:0] o_valid,
  output logic [AW-1:0]    o_addr
);
  logic [DEPTH-1:0]         r_valid;
  logic [DEPTH-1:0][AW-1:0] r_addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid <= '0;
      r_addr  <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_addr[0]  <= i_addr;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_addr[k]  <= r_addr[k-1];
      end
    end
  assign o_valid = r_valid;
  assign o_addr  = r_addr[DEPTH-1];
endmodule

// File: rtl/vector_row_feeder.sv
// vector_row_feeder: aligns SA rows with int/rec SRAM rows for vector_unit and writes results back.
// Optional perf counters enabled by defining VEC_FEEDER_PERF_EN.
module vector_row_feeder import sys_defs::*; #(
  parameter int ADDR_W = 8,
  parameter int VU_LAT = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  vector_row_feeder_if.master bus
);
  localparam int DEPTH = VU_LAT + 1;
  feeder_state_e     r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len, r_issued;
  logic              r_mode;
  row_t              r_sa_row;
  logic              w_cmd_acc, w_sa_acc, w_drained;
  logic [ADDR_W-1:0] w_addr, w_wr_addr;
  logic [DEPTH-1:0]  w_valid;
  assign bus.cmd_ready = r_state == S_IDLE;
  assign bus.sa_ready  = (r_state == S_RUN) && (r_issued < r_len);
  assign w_cmd_acc     = bus.cmd_valid && bus.cmd_ready;
  assign w_sa_acc      = bus.sa_valid && bus.sa_ready;
  assign w_addr        = r_base + r_issued[ADDR_W-1:0];
  // only the final stage may still be live when the last write lands
  assign w_drained     = ~|w_valid[DEPTH-2:0];
  vec_tag_pipe #(.DEPTH(DEPTH), .AW(ADDR_W)) u_tags (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_sa_acc),
    .i_addr  (w_addr),
    .o_valid (w_valid),
    .o_addr  (w_wr_addr)
  );
  assign bus.int_rd_en   = w_sa_acc;
  assign bus.rec_rd_en   = w_sa_acc;
  assign bus.int_rd_addr = w_addr;
  assign bus.rec_rd_addr = w_addr;
  assign bus.vu_enable   = w_valid[0];
  assign bus.vu_mode     = r_mode;
  assign bus.vu_sa_row   = r_sa_row;
  assign bus.vu_int_row  = bus.int_rd_data;
  assign bus.vu_rec_row  = bus.rec_rd_data;
  assign bus.rec_wr_en   = w_valid[DEPTH-1];
  assign bus.rec_wr_addr = w_wr_addr;
  assign bus.rec_wr_data = bus.vu_vec_out;
  assign bus.busy        = r_state != S_IDLE;
  assign bus.done        = r_state == S_DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_mode   <= 1'b0;
      r_sa_row <= '0;
    end else begin
      if (w_sa_acc) begin
        r_sa_row <= bus.sa_row;
        r_issued <= r_issued + 1'b1;
      end
      case (r_state)
        S_IDLE: if (w_cmd_acc) begin
          r_base   <= bus.cmd_base;
          r_len    <= bus.cmd_len;
          r_mode   <= bus.cmd_mode;
          r_issued <= '0;
          r_state  <= (bus.cmd_len == '0) ? S_DONE : S_RUN;
        end
        S_RUN:   if (r_issued == r_len) r_state <= S_DRAIN;
        S_DRAIN: if (w_drained) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
`ifdef VEC_FEEDER_PERF_EN
  logic [31:0] r_perf_busy, r_perf_bubble;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_perf_busy   <= '0;
      r_perf_bubble <= '0;
    end else if (w_cmd_acc) begin
      r_perf_busy   <= '0;
      r_perf_bubble <= '0;
    end else begin
      if ((r_state == S_RUN || r_state == S_DRAIN) && ~&r_perf_busy) r_perf_busy <= r_perf_busy + 1'b1;
      if (bus.sa_ready && !bus.sa_valid && ~&r_perf_bubble) r_perf_bubble <= r_perf_bubble + 1'b1;
    end
  assign bus.perf_busy_cycles   = r_perf_busy;
  assign bus.perf_bubble_cycles = r_perf_bubble;
`endif
endmodule
